// File: rtl/clock_seq_pkg.sv
// Shared definitions for the clock polarity sequencer: FSM state encoding and
// settle-counter width helpers.
package clock_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DROP = 2'd1,
    ST_MAKE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // SETTLE=1 still needs a 1-bit counter to hold the value 0.
  function automatic int settle_w(input int settle);
    return (clog2(settle) < 1) ? 1 : clog2(settle);
  endfunction

endpackage

// File: rtl/clock_polarity_chan.sv
// One clock channel: break-before-make polarity FSM driving a BUFGCTRL S0/S1 pair.
// Optional switch counter built only when CLOCK_POLARITY_SEQUENCER_SWCNT_EN is defined.
module clock_polarity_chan
  import clock_seq_pkg::*;
#(
  parameter int   SETTLE   = 3,
  parameter logic INIT_POL = 1'b0,
  parameter int   CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             pol,
  output logic             ready,
  output logic             ack,
  output logic             sel0,
  output logic             sel1,
  output logic             cur_pol,
  output logic [CNT_W-1:0] sw_cnt
);

  localparam int            SW     = settle_w(SETTLE);
  localparam logic [SW-1:0] RELOAD = SW'(SETTLE - 1);

  state_t        state, state_d;
  logic [SW-1:0] settle_cnt, settle_cnt_d;
  logic          tgt, tgt_d;
  logic          ready_d, ack_d, sel0_d, sel1_d, cur_pol_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      tgt        <= INIT_POL;
      ready      <= 1'b0;
      ack        <= 1'b0;
      sel0       <= ~INIT_POL;
      sel1       <= INIT_POL;
      cur_pol    <= INIT_POL;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_cnt_d;
      tgt        <= tgt_d;
      ready      <= ready_d;
      ack        <= ack_d;
      sel0       <= sel0_d;
      sel1       <= sel1_d;
      cur_pol    <= cur_pol_d;
    end
  end

  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    tgt_d        = tgt;
    case (state)
      ST_IDLE: begin
        if (req && ready) begin
          tgt_d = pol;
          if (pol == cur_pol) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_DROP;
            settle_cnt_d = RELOAD;
          end
        end
      end
      ST_DROP: begin
        if (settle_cnt == '0) begin
          state_d      = ST_MAKE;
          settle_cnt_d = RELOAD;
        end else begin
          settle_cnt_d = settle_cnt - SW'(1);
        end
      end
      ST_MAKE: begin
        if (settle_cnt == '0) state_d = ST_DONE;
        else                  settle_cnt_d = settle_cnt - SW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    ready_d   = (state_d == ST_IDLE);
    ack_d     = (state_d == ST_DONE);
    sel0_d    = sel0;
    sel1_d    = sel1;
    cur_pol_d = cur_pol;
    case (state_d)
      ST_DROP: begin
        sel0_d = 1'b0;
        sel1_d = 1'b0;
      end
      ST_MAKE: begin
        sel0_d = ~tgt_d;
        sel1_d = tgt_d;
      end
      ST_DONE: cur_pol_d = tgt_d;
      default: ;
    endcase
  end

`ifdef CLOCK_POLARITY_SEQUENCER_SWCNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_d == ST_DONE && tgt_d != cur_pol) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sw_cnt = cnt_q;
`else
  assign sw_cnt = '0;
`endif

endmodule

// File: rtl/clock_polarity_sequencer.sv
// NUM_CH independent glitch-free clock polarity switch controllers for BUFGCTRL pairs.
// Per-channel switch counters exist only with CLOCK_POLARITY_SEQUENCER_SWCNT_EN defined.
module clock_polarity_sequencer
  import clock_seq_pkg::*;
#(
  parameter int              NUM_CH   = 4,
  parameter int              SETTLE   = 3,
  parameter logic [NUM_CH-1:0] INIT_POL = '0,
  parameter int              CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH-1:0]       pol,
  output logic [NUM_CH-1:0]       ready,
  output logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH-1:0]       sel0,
  output logic [NUM_CH-1:0]       sel1,
  output logic [NUM_CH-1:0]       cur_pol,
  output logic                    busy,
  output logic [NUM_CH*CNT_W-1:0] sw_cnt
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    clock_polarity_chan #(
      .SETTLE  (SETTLE),
      .INIT_POL(INIT_POL[gi]),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req[gi]),
      .pol    (pol[gi]),
      .ready  (ready[gi]),
      .ack    (ack[gi]),
      .sel0   (sel0[gi]),
      .sel1   (sel1[gi]),
      .cur_pol(cur_pol[gi]),
      .sw_cnt (sw_cnt[gi*CNT_W +: CNT_W])
    );
  end

  assign busy = ~&ready;

endmodule
